// File: rtl/level1_pkg.sv
// Shared constants and types for the level-1 background fetch path.
package level1_pkg;

  localparam int unsigned IMG_W     = 320;
  localparam int unsigned IMG_H     = 240;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned PIPE_LAT  = 3;
  localparam int unsigned MAX_SPEED = 7;
  localparam int unsigned SPEED_W   = $clog2(MAX_SPEED + 1);
  localparam int unsigned SCROLL_W  = 9;
  localparam int unsigned COORD_W   = 10;

  typedef enum logic {PAUSE, SCROLL} scroll_state_t;

  typedef logic [ADDR_W-1:0] rom_addr_t;

endpackage

// File: rtl/level1_scroll_ctl.sv
// Per-frame horizontal scroll offset: vsync edge detect, PAUSE/SCROLL FSM and
// the wrapping scroll_x accumulator. scroll_x only moves on a vsync falling
// edge, so every line of a frame sees the same offset.
module level1_scroll_ctl
  import level1_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                vs_in,
  input  logic                scroll_en,
  input  logic [SPEED_W-1:0]  scroll_speed,
  input  logic                scroll_clr,
  output logic [SCROLL_W-1:0] scroll_x
);

  scroll_state_t         state;
  scroll_state_t         state_nxt;
  logic                  vs_q;
  logic [SCROLL_W-1:0]   scroll_nxt;
  logic                  frame_tick_c;
  logic [COORD_W-1:0]    sum_c;
  logic [COORD_W-1:0]    wrap_c;

  // Frame tick on vsync falling edge; wrapped offset candidate.
  assign frame_tick_c = vs_q & ~vs_in;
  assign sum_c        = COORD_W'(scroll_x) + COORD_W'(scroll_speed);
  assign wrap_c       = (sum_c >= COORD_W'(IMG_W)) ? (sum_c - COORD_W'(IMG_W)) : sum_c;

  // State, offset and vsync history registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= PAUSE;
      vs_q     <= 1'b1;
      scroll_x <= '0;
    end else begin
      state    <= state_nxt;
      vs_q     <= vs_in;
      scroll_x <= scroll_nxt;
    end
  end

  // Next state and offset; a clear wins over any frame-tick advance.
  always_comb begin
    state_nxt  = state;
    scroll_nxt = scroll_x;
    if (scroll_clr) begin
      scroll_nxt = '0;
    end else if (frame_tick_c) begin
      unique case (state)
        PAUSE: begin
          if (scroll_en) state_nxt = SCROLL;
        end
        SCROLL: begin
          if (!scroll_en) state_nxt = PAUSE;
          else            scroll_nxt = SCROLL_W'(wrap_c);
        end
        default: state_nxt = PAUSE;
      endcase
    end
  end

endmodule

// File: rtl/level1_bg_fetch.sv
// Raster-to-ROM address generator for the scrolled 2x-scaled level-1
// background, with a 3-cycle pipeline that keeps blank/hsync/vsync aligned
// with the returned palette index.
module level1_bg_fetch
  import level1_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  logic                blank_in,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                scroll_en,
  input  logic [SPEED_W-1:0]  scroll_speed,
  input  logic                scroll_clr,
  output rom_addr_t           rom_addr,
  input  logic [7:0]          rom_q,
  output logic [7:0]          pixel_index,
  output logic                blank_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic [SCROLL_W-1:0] scroll_x
);

  logic [SCROLL_W-1:0]  xi_c;
  logic [SCROLL_W-1:0]  yi_c;
  logic [COORD_W-1:0]   col_sum_c;
  logic [COORD_W-1:0]   col_c;
  rom_addr_t            addr_c;
  logic                 in_range_c;
  logic                 valid_s1;
  logic                 valid_s2;
  logic [PIPE_LAT-1:0]  blank_sr;
  logic [PIPE_LAT-1:0]  hs_sr;
  logic [PIPE_LAT-1:0]  vs_sr;

  level1_scroll_ctl u_scroll_ctl (
    .Clk          (Clk),
    .Reset        (Reset),
    .vs_in        (vs_in),
    .scroll_en    (scroll_en),
    .scroll_speed (scroll_speed),
    .scroll_clr   (scroll_clr),
    .scroll_x     (scroll_x)
  );

  // Halve coordinates, add scroll with one wrap, and form yi*320+col by shifts.
  assign xi_c       = SCROLL_W'(DrawX >> 1);
  assign yi_c       = SCROLL_W'(DrawY >> 1);
  assign col_sum_c  = COORD_W'(xi_c) + COORD_W'(scroll_x);
  assign col_c      = (col_sum_c >= COORD_W'(IMG_W)) ? (col_sum_c - COORD_W'(IMG_W)) : col_sum_c;
  assign addr_c     = (ADDR_W'(yi_c) << 8) + (ADDR_W'(yi_c) << 6) + ADDR_W'(col_c);
  assign in_range_c = blank_in && (xi_c < SCROLL_W'(IMG_W)) && (yi_c < SCROLL_W'(IMG_H));

  // S1 address/valid, S2 valid, S3 index; control bits ride a matching shift line.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr    <= '0;
      valid_s1    <= 1'b0;
      valid_s2    <= 1'b0;
      pixel_index <= '0;
      blank_sr    <= '0;
      hs_sr       <= '1;
      vs_sr       <= '1;
    end else begin
      rom_addr    <= in_range_c ? addr_c : '0;
      valid_s1    <= in_range_c;
      valid_s2    <= valid_s1;
      pixel_index <= valid_s2 ? rom_q : 8'h00;
      blank_sr    <= {blank_sr[PIPE_LAT-2:0], blank_in};
      hs_sr       <= {hs_sr[PIPE_LAT-2:0], hs_in};
      vs_sr       <= {vs_sr[PIPE_LAT-2:0], vs_in};
    end
  end

  assign blank_out = blank_sr[PIPE_LAT-1];
  assign hs_out    = hs_sr[PIPE_LAT-1];
  assign vs_out    = vs_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_level1_bg_fetch.sv
// Directed bench for level1_bg_fetch with a synchronous ROM model.
module tb_level1_bg_fetch;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank_in;
  logic        hs_in;
  logic        vs_in;
  logic        scroll_en;
  logic [2:0]  scroll_speed;
  logic        scroll_clr;
  logic [16:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  pixel_index;
  logic        blank_out;
  logic        hs_out;
  logic        vs_out;
  logic [8:0]  scroll_x;
  logic        force_ff;

  int n_vec;
  int n_err;

  level1_bg_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank_in     (blank_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .scroll_en    (scroll_en),
    .scroll_speed (scroll_speed),
    .scroll_clr   (scroll_clr),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .pixel_index  (pixel_index),
    .blank_out    (blank_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .scroll_x     (scroll_x)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_fn(input logic [16:0] a);
    return a[7:0] + 8'h5A;
  endfunction

  // Synchronous ROM: data for rom_addr one cycle later.
  always @(posedge Clk) rom_q <= force_ff ? 8'hFF : rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic tick(input logic clr);
    vs_in = 1'b0;
    scroll_clr = clr;
    step(1);
    vs_in = 1'b1;
    scroll_clr = 1'b0;
    step(1);
  endtask

  task automatic set_px(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank_in = b;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    force_ff = 1'b0;
    rom_q = 8'h00;
    set_px(0, 0, 1'b1);
    hs_in = 1'b1;
    vs_in = 1'b1;
    scroll_en = 1'b0;
    scroll_speed = 3'd0;
    scroll_clr = 1'b0;
    step(2);

    // Reset state
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix", 32'(pixel_index), 32'd0);
    chk("rst_blank", 32'(blank_out), 32'd0);
    chk("rst_hs", 32'(hs_out), 32'd1);
    chk("rst_vs", 32'(vs_out), 32'd1);
    chk("rst_scroll", 32'(scroll_x), 32'd0);

    // Release; one-cycle hs/vs pulse to see 3-cycle alignment
    Reset = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    step(1);
    hs_in = 1'b1;
    vs_in = 1'b1;
    chk("a_addr", 32'(rom_addr), 32'd0);
    chk("a_hs1", 32'(hs_out), 32'd1);
    step(1);
    chk("a_hs2", 32'(hs_out), 32'd1);
    step(1);
    chk("a_hs3", 32'(hs_out), 32'd0);
    chk("a_vs3", 32'(vs_out), 32'd0);
    chk("a_pix", 32'(pixel_index), 32'h5A);
    chk("a_blank", 32'(blank_out), 32'd1);
    step(1);
    chk("a_hs4", 32'(hs_out), 32'd1);
    chk("a_noscroll", 32'(scroll_x), 32'd0);

    // Last visible pixel: 239*320+319
    set_px(639, 479, 1'b1);
    step(1);
    chk("b_addr", 32'(rom_addr), 32'd76799);
    step(2);
    chk("b_pix", 32'(pixel_index), 32'h59);

    // Enter SCROLL (no advance on entry), then build scroll_x = 50
    scroll_en = 1'b1;
    scroll_speed = 3'd7;
    tick(1'b0);
    chk("enter_scroll", 32'(scroll_x), 32'd0);
    repeat (7) tick(1'b0);
    scroll_speed = 3'd1;
    tick(1'b0);
    chk("scroll50", 32'(scroll_x), 32'd50);

    // xi=300 + 50 wraps to col 30; row 1 -> 350
    set_px(600, 2, 1'b1);
    step(1);
    chk("c_addr", 32'(rom_addr), 32'd350);
    step(2);
    chk("c_pix", 32'(pixel_index), 32'hB8);

    // Bring scroll_x to 315, then wrap 315+7 -> 2
    scroll_speed = 3'd6;
    tick(1'b0);
    scroll_speed = 3'd7;
    repeat (37) tick(1'b0);
    chk("scroll315", 32'(scroll_x), 32'd315);
    tick(1'b0);
    chk("scroll_wrap", 32'(scroll_x), 32'd2);
    scroll_en = 1'b0;
    repeat (3) tick(1'b0);
    chk("scroll_hold", 32'(scroll_x), 32'd2);

    // xi=319 + 2 wraps to col 1
    set_px(638, 0, 1'b1);
    step(1);
    chk("col_wrap_addr", 32'(rom_addr), 32'd1);

    // Blanked pixel with ROM forced to FF
    force_ff = 1'b1;
    set_px(700, 10, 1'b0);
    step(1);
    chk("d_addr", 32'(rom_addr), 32'd0);
    step(2);
    chk("d_pix", 32'(pixel_index), 32'd0);
    chk("d_blank", 32'(blank_out), 32'd0);
    // Active but xi >= 320
    set_px(700, 10, 1'b1);
    step(3);
    chk("d_xoor_pix", 32'(pixel_index), 32'd0);
    chk("d_xoor_blank", 32'(blank_out), 32'd1);
    // Active but yi >= 240
    set_px(0, 500, 1'b1);
    step(3);
    chk("d_yoor_pix", 32'(pixel_index), 32'd0);
    // Valid pixel passes ROM data straight through
    set_px(0, 0, 1'b1);
    step(3);
    chk("d_valid_ff", 32'(pixel_index), 32'hFF);
    force_ff = 1'b0;

    // Reach 100, then clear on a frame tick
    scroll_en = 1'b1;
    scroll_speed = 3'd7;
    tick(1'b0);
    chk("reenter", 32'(scroll_x), 32'd2);
    repeat (14) tick(1'b0);
    chk("scroll100", 32'(scroll_x), 32'd100);
    scroll_speed = 3'd4;
    tick(1'b1);
    chk("clr_wins", 32'(scroll_x), 32'd0);
    tick(1'b0);
    chk("clr_keeps_state", 32'(scroll_x), 32'd4);
    scroll_speed = 3'd0;
    tick(1'b0);
    chk("speed0", 32'(scroll_x), 32'd4);

    // Mid-line asynchronous reset
    set_px(20, 0, 1'b1);
    hs_in = 1'b0;
    step(3);
    chk("f_pre_addr", 32'(rom_addr), 32'd14);
    chk("f_pre_pix", 32'(pixel_index), 32'h68);
    chk("f_pre_hs", 32'(hs_out), 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("f_addr", 32'(rom_addr), 32'd0);
    chk("f_pix", 32'(pixel_index), 32'd0);
    chk("f_blank", 32'(blank_out), 32'd0);
    chk("f_hs", 32'(hs_out), 32'd1);
    chk("f_vs", 32'(vs_out), 32'd1);
    chk("f_scroll", 32'(scroll_x), 32'd0);
    Reset = 1'b0;
    hs_in = 1'b1;
    step(3);
    chk("f_refill_pix", 32'(pixel_index), 32'h64);
    chk("f_refill_blank", 32'(blank_out), 32'd1);
    chk("f_refill_hs", 32'(hs_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/level1_bg_fetch.md
Name: level1_bg_fetch

Overview:
- Upstream feeder for the level-1 palette lookup.
- Converts VGA raster coordinates into an 8-bit palette index by reading a 320x240 indexed background ROM at 2x pixel scale.
- Applies a per-frame horizontal scroll offset that wraps around the image width.
- Re-times the blank/hsync/vsync signals so they arrive together with the index at the palette and colour output stage.

Parameters:
- IMG_W, 320, background width in ROM pixels.
- IMG_H, 240, background height in ROM pixels.
- ADDR_W, 17, ROM address width; must satisfy 2^17 >= IMG_W*IMG_H = 76800.
- MAX_SPEED, 7, largest legal scroll_speed value.

Ports:
- Clk  in  1  pixel clock, 25 MHz.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current raster column, 0..799.
- DrawY  in  10  current raster row, 0..524.
- blank_in  in  1  1 = active video.
- hs_in  in  1  hsync, active low.
- vs_in  in  1  vsync, active low.
- scroll_en  in  1  1 = advance the scroll offset once per frame.
- scroll_speed  in  3  ROM pixels added to the offset per frame.
- scroll_clr  in  1  synchronous clear of the scroll offset.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_q  in  8  ROM data; synchronous ROM, valid 1 cycle after rom_addr.
- pixel_index  out  8  palette index to the palette stage.
- blank_out  out  1  blank_in delayed to align with pixel_index.
- hs_out  out  1  hs_in delayed to align with pixel_index.
- vs_out  out  1  vs_in delayed to align with pixel_index.
- scroll_x  out  9  current scroll offset, 0..IMG_W-1.

Behaviour:
- Reset values:
  - rom_addr = 0, pixel_index = 0, scroll_x = 0.
  - blank_out = 0; hs_out = 1 and vs_out = 1 (inactive).
  - All delay-line stages take the same values; FSM enters PAUSE.
- Pipeline: fixed latency of 3 Clk from DrawX/DrawY/blank_in/hs_in/vs_in to pixel_index/blank_out/hs_out/vs_out.
  - S1 registers rom_addr.
  - S2: ROM produces rom_q; control signals advance one stage.
  - S3 registers pixel_index.
- Address arithmetic:
  - xi = DrawX >> 1 and yi = DrawY >> 1.
  - col = xi + scroll_x, computed 10 bits wide. If col >= IMG_W then col = col - IMG_W. A single subtract is sufficient because xi < 320 and scroll_x < 320.
  - rom_addr = yi*IMG_W + col, implemented as (yi<<8) + (yi<<6); no multiplier.
- Out of range: when blank_in = 0, or xi >= IMG_W, or yi >= IMG_H, S1 holds rom_addr = 0 and marks the pixel invalid. S3 then outputs pixel_index = 0 regardless of rom_q.
- Scroll FSM, two states, updating only on a frame tick:
  - Frame tick = vs_in falling edge, detected with a 1-cycle registered copy of vs_in.
  - PAUSE -> SCROLL when scroll_en = 1 at a frame tick.
  - SCROLL -> PAUSE when scroll_en = 0 at a frame tick.
  - In SCROLL at each frame tick: scroll_x = (scroll_x + scroll_speed) mod IMG_W, wrapping by a single subtract.
  - scroll_speed = 0 in SCROLL leaves scroll_x unchanged.
- scroll_clr:
  - Has priority over everything: scroll_x = 0 on the next edge and the state is unchanged.
  - If scroll_clr coincides with a frame tick, the clear wins and no advance happens that frame.
- scroll_x changes only during vsync, so every line of a frame uses the same offset and there is no tearing.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). After release the pipeline refills within 3 Clk; output is invalid until then, but blank_out = 0 masks it.

Decomposition:
- Package level1_pkg holds:
  - IMG_W, IMG_H, ADDR_W, PIPE_LAT = 3.
  - typedef enum logic {PAUSE, SCROLL} scroll_state_t.
  - typedef logic [ADDR_W-1:0] rom_addr_t.
- One sub-module, level1_scroll_ctl: contains the FSM, the vs edge detect and the scroll_x accumulator, and outputs scroll_x.
- The top level holds the address arithmetic and the 3-stage delay line.

Test Plan:
- Reset release with DrawX=0, DrawY=0, blank_in=1, scroll_x=0 -> rom_addr=0 after 1 Clk; pixel_index = rom_q(0) after 3 Clk; hs_out/vs_out mirror the inputs 3 Clk late.
- DrawX=639, DrawY=479, scroll_x=0 -> rom_addr = 239*320 + 319 = 76799.
- DrawX=600 (xi=300), scroll_x=50 -> col wraps to 30; with DrawY=2, rom_addr = 320 + 30 = 350.
- scroll_en=1, scroll_speed=7, starting from scroll_x=315, one vs falling edge -> scroll_x = 2. Hold scroll_en=0 for 3 frames -> scroll_x stays 2.
- blank_in=0 at DrawX=700 -> pixel_index = 0 and blank_out = 0 three Clk later, even with rom_q = 8'hFF.
- scroll_clr on the same cycle as a frame tick with scroll_x=100, speed=4 -> scroll_x = 0, not 104. Reset asserted mid-line -> all outputs take reset values in the same cycle, without waiting for a Clk edge.
